// File: rtl/rr_arb_mux_pkg.sv
// Shared parameters and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  localparam int N_CH_DEF = 4;
  localparam int DW_DEF   = 8;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producer streams, the arbiter and one consumer.
// in_last exists only when RR_ARB_MUX_LOCK_EN is defined.
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DW   = DW_DEF
);
  localparam int SW = sel_w(N_CH);

  logic [N_CH-1:0]    in_valid;
  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N_CH-1:0]    in_last;
`endif
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

`ifdef RR_ARB_MUX_LOCK_EN
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`endif

endinterface

// File: rtl/rr_arb_mux_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping mod N_CH.
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic [N_CH-1:0]          req,
  input  logic [sel_w(N_CH)-1:0]   ptr,
  output logic [N_CH-1:0]          gnt_oh,
  output logic [sel_w(N_CH)-1:0]   gnt_idx,
  output logic                     gnt_any
);
  localparam int SW = sel_w(N_CH);

  int idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!gnt_any && req[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = SW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with registered valid/ready output.
// Optional packet lock enabled by defining RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DW   = DW_DEF
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int SW = sel_w(N_CH);

  logic [SW-1:0]   rr_ptr;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic [SW-1:0]   out_sel_q;
  logic            load;
  logic            xfer;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt_oh;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [DW-1:0]   gnt_data;
  logic [SW-1:0]   ptr_next;

`ifdef RR_ARB_MUX_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_ch;

  // While locked, only the owning channel may be granted, even if it idles.
  assign req = locked ? (bus.in_valid & (N_CH'(1) << lock_ch)) : bus.in_valid;
`else
  assign req = bus.in_valid;
`endif

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign load     = !out_valid_q || bus.out_ready;
  assign xfer     = load && gnt_any && !rst;
  assign ptr_next = (gnt_idx == SW'(N_CH - 1)) ? '0 : gnt_idx + SW'(1);

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_oh[i]) gnt_data = bus.in_data[i*DW +: DW];
    end
  end

  assign bus.in_ready  = xfer ? gnt_oh : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      locked      <= 1'b0;
      lock_ch     <= '0;
`endif
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_data;
      out_sel_q   <= gnt_idx;
`ifdef RR_ARB_MUX_LOCK_EN
      if (bus.in_last[gnt_idx]) begin
        locked <= 1'b0;
        rr_ptr <= ptr_next;
      end else begin
        locked  <= 1'b1;
        lock_ch <= gnt_idx;
      end
`else
      rr_ptr      <= ptr_next;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
